if_id_pipe_buf: RTL
===================

Name: if_id_pipe_buf

Overview:
Parametrised successor to the fetch/decode pipeline register. It is a DEPTH-entry elastic buffer with a valid/ready handshake on both sides. It carries the instruction encoding and PC from fetch to decode, supports synchronous flush with NOP injection, and counts downstream stall cycles for performance monitoring. Outputs are fully registered, with no combinational path from any input to any output.

Parameters:
INST_W, 32, instruction encoding width
PC_W, 32, program counter width
DEPTH, 2, buffer entries (legal 1..8; DEPTH>=2 needed for 1 instr/cycle throughput)
NOP_INST, 32'h0000_0013, encoding presented on out_inst when buffer empty (addi x0,x0,0)
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  fetch presents an instruction
in_ready  out  1  buffer can accept this cycle
in_inst  in  INST_W  fetched encoding
in_pc  in  PC_W  PC of fetched encoding
out_valid  out  1  head entry valid for decode
out_ready  in  1  decode consumes head this cycle
out_inst  out  INST_W  head encoding, or NOP_INST when empty
out_pc  out  PC_W  head PC, or last-popped PC when empty
flush  in  1  synchronous kill of all buffered and incoming instructions
level  out  clog2(DEPTH+1)  current occupancy
stall_cnt  out  CNT_W  saturating count of stalled-valid cycles
cnt_clr  in  1  synchronous clear of stall_cnt

Behaviour:
- Reset (rst_n=0, takes effect immediately, independent of clk): level=0, pointers=0, out_valid=0, out_inst=NOP_INST, out_pc=0, stall_cnt=0, in_ready=1 once released.
- Storage: circular FIFO, wr_ptr/rd_ptr mod DEPTH. Wrap-around is required for any DEPTH, including non-powers of two.
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- in_ready = (level < DEPTH). It derives from registered state only and must not depend on out_ready. When full, a same-cycle pop does not enable a push.
- out_valid = (level != 0). out_inst and out_pc come from registered head copies, not a combinational mux from in_*.
- Latency: an instruction pushed at edge N is visible on out_* after edge N (1 cycle). Order is preserved strictly.
- Simultaneous push and pop when 0<level<DEPTH: level is unchanged and both pointers advance.
- Push into empty buffer with no pop: out_valid=1 next cycle with the pushed data.
- Pop of the last entry with no push: next cycle out_valid=0, out_inst=NOP_INST, and out_pc holds the PC of the popped entry.
- Flush has the highest priority. At the edge where flush=1:
  - level=0 and pointers=0.
  - A concurrent push is discarded and a concurrent pop is considered not taken.
  - Next cycle: out_valid=0, out_inst=NOP_INST, out_pc=0, in_ready=1.
  - Flush held for multiple cycles keeps the buffer empty and discards every push.
- stall_cnt:
  - Increments by 1 on each edge where out_valid=1 and out_ready=0.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - cnt_clr=1 forces it to 0, taking priority over increment.
  - Flush does not affect it.
- X on in_valid or out_ready is not tolerated. The verification environment flags any X on these inputs while rst_n=1.
- in_inst and in_pc are don't-care when in_valid=0 and must not be stored.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with level=2 -> before the next edge, out_valid=0, out_inst=0x00000013, out_pc=0, level=0, stall_cnt=0.
- Streaming: out_ready=1; push PC 0x100/0x104/0x108/0x10C on 4 consecutive cycles -> out_valid high from cycle+1, PCs emerge in order one per cycle, level never exceeds 1, stall_cnt=0.
- Backpressure: DEPTH=2, out_ready=0, push 0x200/0x204/0x208 -> level=2, in_ready=0 on the third attempt, 0x208 not stored; stall_cnt increments each held cycle. Raise out_ready -> 0x200 then 0x204 are output.
- Flush: level=2 with in_valid=1 (PC 0x300) and flush=1 on the same edge -> next cycle level=0, out_valid=0, out_inst=0x00000013, out_pc=0; 0x300 never appears.
- Wrap and saturation: DEPTH=3, CNT_W=4; push/pop 10 entries with alternating out_ready -> order preserved across pointer wrap. Hold out_valid=1 with out_ready=0 for 20 cycles -> stall_cnt=15. Pulse cnt_clr -> stall_cnt=0.
- Empty output: pop the final entry PC 0x400 -> next cycle out_valid=0, out_inst=0x00000013, out_pc=0x400.

Source files
------------

// File: rtl/if_id_pipe_buf.sv
// if_id_pipe_buf: elastic fetch-to-decode pipeline buffer.
// DEPTH-entry circular FIFO with valid/ready on both sides.
// The head entry is mirrored into output registers, so no input reaches an output combinationally.
// A synchronous flush empties the buffer and presents a NOP.
// A saturating counter records the cycles where decode stalls a valid head.
module if_id_pipe_buf #(
    parameter int INST_W = 32,
    parameter int PC_W = 32,
    parameter int DEPTH = 2,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(32'h0000_0013),
    parameter int CNT_W = 16,
    localparam int LVL_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] in_inst,
    input  logic [PC_W-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [PC_W-1:0]   out_pc,
    input  logic              flush,
    output logic [LVL_W-1:0]  level,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              cnt_clr
);

    logic [INST_W-1:0] r_instMem [DEPTH];
    logic [PC_W-1:0]   r_pcMem [DEPTH];
    logic [PTR_W-1:0]  r_wrPtr;
    logic [PTR_W-1:0]  r_rdPtr;
    logic [LVL_W-1:0]  r_level;
    logic              r_outValid;
    logic [INST_W-1:0] r_outInst;
    logic [PC_W-1:0]   r_outPc;
    logic [CNT_W-1:0]  r_stallCnt;

    logic              w_inReady;
    logic              w_push;
    logic              w_pop;
    logic [PTR_W-1:0]  w_wrNext;
    logic [PTR_W-1:0]  w_rdNext;
    logic [LVL_W-1:0]  w_levelNext;
    logic [LVL_W-1:0]  w_levelAfterPop;
    logic              w_headFromIn;

    // Pointer advance with explicit wrap, so non-power-of-two depths work
    function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // in_ready depends only on the registered level, so a pop never frees a slot in the same cycle
    assign w_inReady = (r_level < LVL_W'(DEPTH));
    assign w_push    = in_valid & w_inReady;
    assign w_pop     = r_outValid & out_ready;
    assign w_wrNext  = w_push ? ptrInc(r_wrPtr) : r_wrPtr;
    assign w_rdNext  = w_pop ? ptrInc(r_rdPtr) : r_rdPtr;

    assign w_levelAfterPop = w_pop ? (r_level - 1'b1) : r_level;
    assign w_headFromIn    = w_push && (w_levelAfterPop == '0);

    // Occupancy after this edge's push/pop
    always_comb begin
        w_levelNext = r_level;
        if (w_push && !w_pop) begin
            w_levelNext = r_level + 1'b1;
        end else if (!w_push && w_pop) begin
            w_levelNext = r_level - 1'b1;
        end
    end

    // Entry storage; a push in a flush cycle is dropped
    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_instMem[r_wrPtr] <= in_inst;
            r_pcMem[r_wrPtr]   <= in_pc;
        end
    end

    // Pointers and level, cleared by flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else if (flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else begin
            r_wrPtr <= w_wrNext;
            r_rdPtr <= w_rdNext;
            r_level <= w_levelNext;
        end
    end

    // Registered head copy; when the buffer empties, out_pc keeps the last popped PC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outValid <= 1'b0;
            r_outInst  <= NOP_INST;
            r_outPc    <= '0;
        end else if (flush) begin
            r_outValid <= 1'b0;
            r_outInst  <= NOP_INST;
            r_outPc    <= '0;
        end else if (w_levelNext == '0) begin
            r_outValid <= 1'b0;
            r_outInst  <= NOP_INST;
        end else begin
            r_outValid <= 1'b1;
            if (w_headFromIn) begin
                r_outInst <= in_inst;
                r_outPc   <= in_pc;
            end else begin
                r_outInst <= r_instMem[w_rdNext];
                r_outPc   <= r_pcMem[w_rdNext];
            end
        end
    end

    // Saturating stall counter; clear wins over increment and flush leaves it alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stallCnt <= '0;
        end else if (cnt_clr) begin
            r_stallCnt <= '0;
        end else if (r_outValid && !out_ready && (r_stallCnt != '1)) begin
            r_stallCnt <= r_stallCnt + 1'b1;
        end
    end

    assign in_ready  = w_inReady;
    assign out_valid = r_outValid;
    assign out_inst  = r_outInst;
    assign out_pc    = r_outPc;
    assign level     = r_level;
    assign stall_cnt = r_stallCnt;

endmodule
